// File: rtl/pp_pkg.sv
// Shared types and helpers for the perceptron branch predictor.
package pp_pkg;

  typedef enum logic [1:0] {StIdle, StCompute, StWait, StUpdate} state_e;

  // Weight type at the default WEIGHT_BITS; parametrised users declare their own.
  typedef logic signed [7:0] weight_t;

  function automatic int unsigned idx_bits(input int unsigned num_perceptrons);
    return $clog2(num_perceptrons);
  endfunction

  function automatic int unsigned beats(input int unsigned hist_len, input int unsigned lanes);
    return hist_len / lanes;
  endfunction

  function automatic int unsigned y_bits(input int unsigned weight_bits,
                                         input int unsigned hist_len);
    return weight_bits + $clog2(hist_len + 1);
  endfunction

  // Symmetric saturation: the most negative code is never produced.
  function automatic int sat_inc(input int w, input logic up, input int max_mag);
    if (up) return (w >= max_mag) ? max_mag : w + 1;
    return (w <= -max_mag) ? -max_mag : w - 1;
  endfunction

endpackage

// File: rtl/perceptron_predictor_if.sv
// Request/prediction/result handshake bundle for perceptron_predictor.
interface perceptron_predictor_if #(
  parameter int unsigned ADDR_WID = 32,
  parameter int unsigned Y_BITS   = 13
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDR_WID-1:0]      req_addr;
  logic                     pred_valid;
  logic                     pred_taken;
  logic signed [Y_BITS-1:0] pred_y;
  logic                     res_valid;
  logic                     res_ready;
  logic                     res_taken;
  logic [31:0]              perf_mispred;

  modport master (
    output req_valid, req_addr, res_valid, res_taken,
    input  req_ready, pred_valid, pred_taken, pred_y, res_ready, perf_mispred
  );

  modport slave (
    input  req_valid, req_addr, res_valid, res_taken,
    output req_ready, pred_valid, pred_taken, pred_y, res_ready, perf_mispred
  );
endinterface

// File: rtl/pp_ghr.sv
// Global history register: bit 0 is the most recent outcome; snapshot held per branch.
module pp_ghr #(
  parameter int unsigned HIST_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en_i,
  input  logic                bit_i,
  input  logic                snap_en_i,
  output logic [HIST_LEN-1:0] ghr_o,
  output logic [HIST_LEN-1:0] snap_o
);
  logic [HIST_LEN-1:0] ghr_q, ghr_d, snap_q, snap_d;

  always_comb begin
    ghr_d  = ghr_q;
    snap_d = snap_q;
    if (shift_en_i) ghr_d = {ghr_q[HIST_LEN-2:0], bit_i};
    if (snap_en_i)  snap_d = ghr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q  <= '0;
      snap_q <= '0;
    end else begin
      ghr_q  <= ghr_d;
      snap_q <= snap_d;
    end
  end

  assign ghr_o  = ghr_q;
  assign snap_o = snap_q;
endmodule

// File: rtl/perceptron_predictor.sv
// Perceptron branch direction predictor: one branch in flight, LANES-wide time-multiplexed MAC.
module perceptron_predictor
  import pp_pkg::*;
#(
  parameter int unsigned ADDR_WID        = 32,
  parameter int unsigned NUM_PERCEPTRONS = 256,
  parameter int unsigned HIST_LEN        = 16,
  parameter int unsigned WEIGHT_BITS     = 8,
  parameter int unsigned LANES           = 4,
  parameter int unsigned THETA           = 44,
  parameter int unsigned HASH_XOR        = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  perceptron_predictor_if.slave bus
);
  localparam int unsigned IdxBits  = idx_bits(NUM_PERCEPTRONS);
  localparam int unsigned Beats    = beats(HIST_LEN, LANES);
  localparam int unsigned YBits    = y_bits(WEIGHT_BITS, HIST_LEN);
  localparam int unsigned BeatBits = $clog2(Beats + 1);
  localparam int          WMax     = (2 ** (WEIGHT_BITS - 1)) - 1;
  localparam int          ThetaI   = int'(THETA);
  localparam logic [BeatBits-1:0] LastBeat    = BeatBits'(Beats - 1);
  localparam logic [BeatBits-1:0] ComputeDone = BeatBits'(Beats);

  typedef logic signed [WEIGHT_BITS-1:0] wt_t;
  typedef logic signed [YBits-1:0]       acc_t;

  state_e              state_q, state_d;
  logic [IdxBits-1:0]  idx_q, idx_d, req_idx;
  acc_t                acc_q, acc_d, pred_y_q, pred_y_d, lane_sum;
  logic [BeatBits-1:0] beat_q, beat_d;
  logic                pred_taken_q, pred_taken_d, outcome_q, outcome_d;
  logic [31:0]         mispred_q, mispred_d;
  logic                ghr_shift, snap_en, w_we, b_we, train;
  logic [HIST_LEN-1:0] ghr, snap;
  logic signed [31:0]  y_ext;
  int unsigned         base;
  logic                unused_addr;

  wt_t w_q    [NUM_PERCEPTRONS][HIST_LEN];
  wt_t bias_q [NUM_PERCEPTRONS];
  wt_t lane_new [LANES];
  wt_t bias_new;

  pp_ghr #(.HIST_LEN(HIST_LEN)) u_ghr (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (ghr_shift),
    .bit_i      (bus.res_taken),
    .snap_en_i  (snap_en),
    .ghr_o      (ghr),
    .snap_o     (snap)
  );

  assign unused_addr = ^bus.req_addr[ADDR_WID-1:IdxBits];

  always_comb begin
    req_idx = bus.req_addr[IdxBits-1:0];
    if (HASH_XOR != 0) req_idx = req_idx ^ IdxBits'(ghr);
  end

  // Per-beat lane datapath shared by COMPUTE (accumulate) and UPDATE (train).
  always_comb begin
    base     = (beat_q < ComputeDone) ? 32'(beat_q) * LANES : 0;
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (snap[base + l]) lane_sum = lane_sum + acc_t'(w_q[idx_q][base + l]);
      else                lane_sum = lane_sum - acc_t'(w_q[idx_q][base + l]);
      lane_new[l] = wt_t'(sat_inc(int'(w_q[idx_q][base + l]),
                                  outcome_q == snap[base + l], WMax));
    end
    bias_new = wt_t'(sat_inc(int'(bias_q[idx_q]), outcome_q, WMax));
  end

  assign y_ext = 32'(pred_y_q);
  assign train = (bus.res_taken != pred_taken_q) || (y_ext <= ThetaI && y_ext >= -ThetaI);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    beat_d       = beat_q;
    pred_y_d     = pred_y_q;
    pred_taken_d = pred_taken_q;
    outcome_d    = outcome_q;
    mispred_d    = mispred_q;
    ghr_shift    = 1'b0;
    snap_en      = 1'b0;
    w_we         = 1'b0;
    b_we         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          idx_d   = req_idx;
          snap_en = 1'b1;
          acc_d   = acc_t'(bias_q[req_idx]);
          beat_d  = '0;
          state_d = StCompute;
        end
      end
      StCompute: begin
        if (beat_q == ComputeDone) begin
          pred_y_d     = acc_q;
          pred_taken_d = ~acc_q[YBits-1];
          state_d      = StWait;
        end else begin
          acc_d  = acc_q + lane_sum;
          beat_d = beat_q + 1'b1;
        end
      end
      StWait: begin
        if (bus.res_valid) begin
          ghr_shift = 1'b1;
          outcome_d = bus.res_taken;
          if (bus.res_taken != pred_taken_q && mispred_q != '1) mispred_d = mispred_q + 32'd1;
          beat_d    = '0;
          state_d   = train ? StUpdate : StIdle;
        end
      end
      StUpdate: begin
        w_we   = 1'b1;
        b_we   = (beat_q == '0);
        beat_d = beat_q + 1'b1;
        if (beat_q == LastBeat) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      acc_q        <= '0;
      beat_q       <= '0;
      pred_y_q     <= '0;
      pred_taken_q <= 1'b0;
      outcome_q    <= 1'b0;
      mispred_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      beat_q       <= beat_d;
      pred_y_q     <= pred_y_d;
      pred_taken_q <= pred_taken_d;
      outcome_q    <= outcome_d;
      mispred_q    <= mispred_d;
    end
  end

  // Flop table so the whole array clears on async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_PERCEPTRONS; n++) begin
        bias_q[n] <= '0;
        for (int h = 0; h < HIST_LEN; h++) w_q[n][h] <= '0;
      end
    end else begin
      if (w_we) begin
        for (int l = 0; l < LANES; l++) w_q[idx_q][base + l] <= lane_new[l];
      end
      if (b_we) bias_q[idx_q] <= bias_new;
    end
  end

  assign bus.req_ready    = (state_q == StIdle);
  assign bus.pred_valid   = (state_q == StWait);
  assign bus.res_ready    = (state_q == StWait);
  assign bus.pred_taken   = pred_taken_q;
  assign bus.pred_y       = pred_y_q;
  assign bus.perf_mispred = mispred_q;
endmodule

// File: tb/tb_perceptron_predictor.sv
// Directed bench: default config, saturation config (WEIGHT_BITS=4) and THETA=0 config.
module tb_perceptron_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [15:0] exp_ghr = '0;

  always #5 clk = ~clk;

  perceptron_predictor_if #(.ADDR_WID(32), .Y_BITS(13)) if0 ();
  perceptron_predictor_if #(.ADDR_WID(32), .Y_BITS(9))  if1 ();
  perceptron_predictor_if #(.ADDR_WID(32), .Y_BITS(13)) if2 ();

  perceptron_predictor dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  perceptron_predictor #(.WEIGHT_BITS(4), .THETA(200)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  perceptron_predictor #(.THETA(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic issue0(input logic [31:0] a, output int lat);
    int n = 0;
    while (!if0.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if0.req_valid = 1'b1; if0.req_addr = a;
    @(posedge clk); #1; if0.req_valid = 1'b0;
    lat = 0;
    while (!if0.pred_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic resolve0(input logic t);
    if0.res_valid = 1'b1; if0.res_taken = t;
    @(posedge clk); #1; if0.res_valid = 1'b0;
    exp_ghr = {exp_ghr[14:0], t};
  endtask

  task automatic issue1(input logic [31:0] a, output int lat);
    int n = 0;
    while (!if1.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if1.req_valid = 1'b1; if1.req_addr = a;
    @(posedge clk); #1; if1.req_valid = 1'b0;
    lat = 0;
    while (!if1.pred_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic resolve1(input logic t);
    if1.res_valid = 1'b1; if1.res_taken = t;
    @(posedge clk); #1; if1.res_valid = 1'b0;
  endtask

  task automatic issue2(input logic [31:0] a, output int lat);
    int n = 0;
    while (!if2.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if2.req_valid = 1'b1; if2.req_addr = a;
    @(posedge clk); #1; if2.req_valid = 1'b0;
    lat = 0;
    while (!if2.pred_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic resolve2(input logic t);
    if2.res_valid = 1'b1; if2.res_taken = t;
    @(posedge clk); #1; if2.res_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (if0.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", if0.req_ready); end
    tests++; if (if0.pred_valid !== 1'b0) begin fails++; $display("FAIL reset_pred_valid got %b want 0", if0.pred_valid); end
    tests++; if (if0.pred_taken !== 1'b0) begin fails++; $display("FAIL reset_pred_taken got %b want 0", if0.pred_taken); end
    tests++; if (if0.pred_y !== 13'sd0) begin fails++; $display("FAIL reset_pred_y got %0d want 0", if0.pred_y); end
    tests++; if (if0.res_ready !== 1'b0) begin fails++; $display("FAIL reset_res_ready got %b want 0", if0.res_ready); end
    tests++; if (if0.perf_mispred !== 32'd0) begin fails++; $display("FAIL reset_mispred got %0d want 0", if0.perf_mispred); end
  endtask

  task automatic test_first_predict();
    int lat;
    issue0(32'h10, lat);
    tests++; if (lat != 5) begin fails++; $display("FAIL first_latency got %0d want 5", lat); end
    tests++; if (if0.pred_y !== 13'sd0) begin fails++; $display("FAIL first_pred_y got %0d want 0", if0.pred_y); end
    tests++; if (if0.pred_taken !== 1'b1) begin fails++; $display("FAIL first_taken got %b want 1", if0.pred_taken); end
    resolve0(1'b1);
    tests++; if (dut0.u_ghr.ghr_q !== exp_ghr) begin fails++; $display("FAIL first_ghr got %h want %h", dut0.u_ghr.ghr_q, exp_ghr); end
    issue0(32'h10, lat);
    tests++; if (if0.pred_y !== 13'sd15) begin fails++; $display("FAIL trained_pred_y got %0d want 15", if0.pred_y); end
    tests++; if (if0.pred_taken !== 1'b1) begin fails++; $display("FAIL trained_taken got %b want 1", if0.pred_taken); end
  endtask

  task automatic test_mispredict();
    int n = 0;
    int lat;
    resolve0(1'b0);
    tests++; if (if0.perf_mispred !== 32'd1) begin fails++; $display("FAIL mispred_count got %0d want 1", if0.perf_mispred); end
    while (!if0.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    tests++; if (n != 4) begin fails++; $display("FAIL update_cycles got %0d want 4", n); end
    tests++; if (dut0.u_ghr.ghr_q !== exp_ghr) begin fails++; $display("FAIL mispred_ghr got %h want %h", dut0.u_ghr.ghr_q, exp_ghr); end
    issue0(32'h10, lat);
    tests++; if (if0.pred_y !== 13'sd2) begin fails++; $display("FAIL retrained_pred_y got %0d want 2", if0.pred_y); end
    resolve0(1'b1);
  endtask

  task automatic test_stall_and_ignore();
    int n = 0;
    int accepts = 0;
    while (!if0.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if0.req_valid = 1'b1; if0.req_addr = 32'h20;
    for (int c = 0; c < 8; c++) begin
      if (if0.req_ready && if0.req_valid) accepts++;
      @(posedge clk); #1;
    end
    if0.req_valid = 1'b0;
    tests++; if (accepts != 1) begin fails++; $display("FAIL stall_accepts got %0d want 1", accepts); end
    tests++; if (if0.pred_valid !== 1'b1) begin fails++; $display("FAIL stall_pred_valid got %b want 1", if0.pred_valid); end
    resolve0(1'b1);
    n = 0;
    while (!if0.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if0.res_valid = 1'b1; if0.res_taken = 1'b0;
    @(posedge clk); #1; if0.res_valid = 1'b0;
    tests++; if (dut0.u_ghr.ghr_q !== exp_ghr) begin fails++; $display("FAIL idle_res_ghr got %h want %h", dut0.u_ghr.ghr_q, exp_ghr); end
    tests++; if (if0.perf_mispred !== 32'd1) begin fails++; $display("FAIL idle_res_mispred got %0d want 1", if0.perf_mispred); end
  endtask

  task automatic test_saturation();
    int lat;
    int bad_lat = 0;
    for (int n = 1; n <= 40; n++) begin
      issue1(32'h0, lat);
      if (lat != 5) bad_lat++;
      if (n == 17) begin
        tests++;
        if (dut1.w_q[0][15] !== 4'sb1001) begin
          fails++; $display("FAIL sat_neg_w15 got %0d want -7", dut1.w_q[0][15]);
        end
      end
      resolve1(1'b1);
    end
    tests++; if (bad_lat != 0) begin fails++; $display("FAIL sat_latency bad=%0d want 0", bad_lat); end
    issue1(32'h0, lat);
    tests++; if (if1.pred_y !== 9'sd119) begin fails++; $display("FAIL sat_pred_y got %0d want 119", if1.pred_y); end
    tests++; if (dut1.bias_q[0] !== 4'sd7) begin fails++; $display("FAIL sat_bias got %0d want 7", dut1.bias_q[0]); end
    resolve1(1'b1);
    issue1(32'h0, lat);
    tests++; if (if1.pred_y !== 9'sd119) begin fails++; $display("FAIL sat_hold_pred_y got %0d want 119", if1.pred_y); end
    resolve1(1'b1);
  endtask

  task automatic test_no_train();
    int lat;
    issue2(32'h5, lat);
    resolve2(1'b1);
    for (int n = 0; n < 7; n++) begin
      issue2(32'h9, lat);
      resolve2(1'b1);
    end
    issue2(32'h5, lat);
    tests++; if (if2.pred_y !== 13'sd1) begin fails++; $display("FAIL theta0_pred_y got %0d want 1", if2.pred_y); end
    tests++; if (if2.pred_taken !== 1'b1) begin fails++; $display("FAIL theta0_taken got %b want 1", if2.pred_taken); end
    resolve2(1'b1);
    tests++; if (if2.req_ready !== 1'b1) begin fails++; $display("FAIL theta0_ready got %b want 1", if2.req_ready); end
    tests++; if (dut2.bias_q[5] !== 8'sd1) begin fails++; $display("FAIL theta0_bias got %0d want 1", dut2.bias_q[5]); end
    tests++; if (dut2.w_q[5][0] !== -8'sd1) begin fails++; $display("FAIL theta0_w0 got %0d want -1", dut2.w_q[5][0]); end
    issue2(32'h5, lat);
    tests++; if (if2.pred_y !== -13'sd1) begin fails++; $display("FAIL theta0_next_y got %0d want -1", if2.pred_y); end
    tests++; if (if2.pred_taken !== 1'b0) begin fails++; $display("FAIL theta0_next_taken got %b want 0", if2.pred_taken); end
    resolve2(1'b0);
  endtask

  task automatic test_reset_mid_update();
    int lat;
    issue0(32'h10, lat);
    tests++; if (if0.pred_y !== 13'sd11) begin fails++; $display("FAIL pre_reset_pred_y got %0d want 11", if0.pred_y); end
    resolve0(1'b1);
    @(posedge clk); #1;
    tests++; if (if0.req_ready !== 1'b0) begin fails++; $display("FAIL in_update_ready got %b want 0", if0.req_ready); end
    rst_n = 1'b0; #1;
    exp_ghr = '0;
    tests++; if (if0.req_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got %b want 1", if0.req_ready); end
    tests++; if (if0.pred_y !== 13'sd0) begin fails++; $display("FAIL midrst_pred_y got %0d want 0", if0.pred_y); end
    tests++; if (if0.perf_mispred !== 32'd0) begin fails++; $display("FAIL midrst_mispred got %0d want 0", if0.perf_mispred); end
    tests++; if (if0.res_ready !== 1'b0) begin fails++; $display("FAIL midrst_res_ready got %b want 0", if0.res_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    issue0(32'h10, lat);
    tests++; if (if0.pred_y !== 13'sd0) begin fails++; $display("FAIL postrst_pred_y got %0d want 0", if0.pred_y); end
    tests++; if (if0.pred_taken !== 1'b1) begin fails++; $display("FAIL postrst_taken got %b want 1", if0.pred_taken); end
    tests++; if (dut0.u_ghr.ghr_q !== exp_ghr) begin fails++; $display("FAIL postrst_ghr got %h want %h", dut0.u_ghr.ghr_q, exp_ghr); end
    resolve0(1'b1);
  endtask

  initial begin
    if0.req_valid = 1'b0; if0.req_addr = '0; if0.res_valid = 1'b0; if0.res_taken = 1'b0;
    if1.req_valid = 1'b0; if1.req_addr = '0; if1.res_valid = 1'b0; if1.res_taken = 1'b0;
    if2.req_valid = 1'b0; if2.req_addr = '0; if2.res_valid = 1'b0; if2.res_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_first_predict();
    test_mispredict();
    test_stall_and_ignore();
    test_saturation();
    test_no_train();
    test_reset_mid_update();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/perceptron_predictor.md
Name: perceptron_predictor

Overview:
Parametrised perceptron branch direction predictor with a valid/ready request/result handshake and a global history register (GHR) inside the block. Adds a bias weight, saturating signed weights, optional PC^GHR index hashing, a time-multiplexed multiply-accumulate of LANES weights per cycle, and a misprediction counter. Handles one branch at a time: predict, wait for the resolved outcome, train, then shift history.

Parameters:
ADDR_WID, 32, branch address width
NUM_PERCEPTRONS, 256, table entries; power of 2, at least 2; IDX_BITS = clog2(NUM_PERCEPTRONS)
HIST_LEN, 16, GHR length; must be a multiple of LANES
WEIGHT_BITS, 8, signed weight width
LANES, 4, weights accumulated per cycle; BEATS = HIST_LEN/LANES
THETA, 44, training threshold, floor(1.93*HIST_LEN+14)
HASH_XOR, 0, 0: idx = addr[IDX_BITS-1:0]; 1: idx = addr[IDX_BITS-1:0] ^ ghr[IDX_BITS-1:0]

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  prediction request
req_ready  out  1  high only in IDLE
req_addr  in  ADDR_WID  branch address
pred_valid  out  1  prediction held valid in WAIT
pred_taken  out  1  predicted direction
pred_y  out  Y_BITS  signed perceptron output; Y_BITS = WEIGHT_BITS + clog2(HIST_LEN+1)
res_valid  in  1  resolved outcome valid
res_ready  out  1  high only in WAIT
res_taken  in  1  actual direction
perf_mispred  out  32  misprediction count, saturates at all-ones

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state IDLE; all weights and bias 0; GHR 0; req_ready 1; pred_valid 0; pred_taken 0; pred_y 0; res_ready 0; perf_mispred 0.
- Reset mid-operation: the same reset values apply immediately. Any in-flight prediction or training is discarded.
- GHR bit 0 is the most recent outcome. Term i is +w[i] if snapshot bit i is 1, otherwise -w[i].
- FSM states: IDLE, COMPUTE, WAIT, UPDATE.
- IDLE: on req_valid & req_ready, latch idx, latch a GHR snapshot, set acc = bias[idx], go to COMPUTE.
- COMPUTE: for BEATS cycles, add LANES terms per beat (beat k covers bits k*LANES .. k*LANES+LANES-1). After the last beat, register pred_y = acc and pred_taken = (acc >= 0), then go to WAIT.
- Latency: pred_valid rises BEATS+1 cycles after the accepting edge (5 cycles at defaults).
- WAIT: pred_valid = 1 and res_ready = 1. On res_valid, do all of the following in the same edge:
  - shift res_taken into GHR bit 0;
  - increment perf_mispred if res_taken != pred_taken;
  - set train = (res_taken != pred_taken) || (|pred_y| <= THETA);
  - go to UPDATE if train, otherwise go to IDLE;
  - drop pred_valid.
- UPDATE: over BEATS cycles, adjust the latched idx entry using the snapshot GHR (the pre-shift history), then go to IDLE.
  - Bias: +1 if taken, -1 if not.
  - Weight i: +1 if res_taken equals snapshot bit i, otherwise -1.
- Saturation: weights and bias saturate to ±(2^(WEIGHT_BITS-1)-1). The most negative code is never produced, and values never wrap.
- Arithmetic: the accumulator is Y_BITS signed and cannot overflow.
- Ignored inputs: req_valid outside IDLE is not accepted (stalls). res_valid outside WAIT has no effect on GHR, weights or counter.
- req_ready returns 1 on the first cycle after the last UPDATE beat, or on the cycle after result acceptance if there is no training.
- The weight table is a flop array so it can be reset asynchronously. The table and bias are read and written only at the latched idx.

Decomposition:
- Shared package pp_pkg: FSM state enum; saturating add function sat_inc(w, dir); derived localparams IDX_BITS, BEATS, Y_BITS; weight typedef.
- One natural sub-module, pp_ghr: the GHR shift register with async reset, shift enable and snapshot output.

Test Plan:
- Defaults, after reset, addr 0x10: pred_y=0, pred_taken=1, pred_valid 5 cycles after accept. res_taken=1 trains the entry: bias=1, all w=-1, GHR=0x0001. Next request to 0x10 gives pred_y=15, pred_taken=1.
- res_taken=0 for that second request: perf_mispred=1, UPDATE runs 4 cycles, req_ready high on the cycle after.
- WEIGHT_BITS=4, THETA=200, 40 taken branches to addr 0: bias and all weights reach +7 and stay there (never -8); pred_y=119.
- THETA=0, trained entry giving pred_y=1 with res_taken=1: no UPDATE, req_ready high 1 cycle after res accept, weights unchanged.
- req_valid held through COMPUTE: exactly one accept. res_valid pulsed in IDLE: GHR and perf_mispred unchanged.
- rst_n low during UPDATE: outputs return to reset values. Next request to the same addr gives pred_y=0 and GHR=0.
